// File: rtl/sd_pkg.sv
// Shared definitions for the multi-phase sigma-delta synthesiser.
//   SD_MODE_ONEHOT / SD_MODE_THERM : values carried on mode_in / mode_q.
//   sd_idxw(n)                     : width of a ring index for n phases,
//                                    never narrower than one bit.
package sd_pkg;

  localparam logic SD_MODE_ONEHOT = 1'b0;
  localparam logic SD_MODE_THERM  = 1'b1;

  function automatic int sd_idxw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sd_phase_decode.sv
// Combinational phase decoder: ring index + mode -> NPHASE output lines.
//   idx    : current ring index (0..NPHASE-1)
//   mode   : SD_MODE_ONEHOT -> only line idx high
//            SD_MODE_THERM  -> floor(NPHASE/2) consecutive lines high,
//                              starting at line idx and wrapping upward
//   sd_out : decoded phase lines
module sd_phase_decode
  import sd_pkg::*;
#(
  parameter int NPHASE = 4
) (
  input  logic [sd_idxw(NPHASE)-1:0] idx,
  input  logic                       mode,
  output logic [NPHASE-1:0]          sd_out
);

  always_comb begin
    sd_out = '0;
    for (int i = 0; i < NPHASE; i++) begin
      if (mode == SD_MODE_THERM) begin
        // Distance of line i ahead of idx around the ring.
        sd_out[i] = (((i + NPHASE - int'(idx)) % NPHASE) < (NPHASE / 2));
      end else begin
        sd_out[i] = (int'(idx) == i);
      end
    end
  end

endmodule

// File: rtl/sd_multiphase_synth.sv
// Multi-phase sigma-delta frequency synthesiser.
// A first-order accumulator adds the active frequency word every enabled
// cycle; each carry steps a ring of NPHASE states, decoded to NPHASE lines.
//   clk, reset : clock, synchronous active-high reset
//   en         : accumulate enable (0 freezes acc and ring)
//   kin        : frequency word offered for loading
//   mode_in    : output mode travelling with kin (0 one-hot, 1 thermometer)
//   kin_valid  : kin/mode_in offered
//   kin_ready  : a new word can be taken this cycle
//   sd_out     : decoded phase outputs
//   phase_idx  : current ring index
//   wrap       : one-cycle pulse after the ring steps from NPHASE-1 to 0
module sd_multiphase_synth
  import sd_pkg::*;
#(
  parameter int NPHASE     = 4,
  parameter int BITWIDTH   = 32,
  parameter int RESETPHASE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [BITWIDTH-1:0]        kin,
  input  logic                       mode_in,
  input  logic                       kin_valid,
  output logic                       kin_ready,
  output logic [NPHASE-1:0]          sd_out,
  output logic [sd_idxw(NPHASE)-1:0] phase_idx,
  output logic                       wrap
);

  localparam int IDXW = sd_idxw(NPHASE);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NPHASE - 1);
  localparam logic [IDXW-1:0] RESET_IDX = IDXW'(RESETPHASE);

  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] k_active;
  logic [BITWIDTH-1:0] k_pend;
  logic [IDXW-1:0]     idx;
  logic                mode_q;
  logic                mode_pend;
  logic                pending;
  logic                wrap_q;

  logic [BITWIDTH:0]   sum;
  logic                carry;
  logic                at_wrap;
  logic                transfer;
  logic                apply;

  assign sum     = {1'b0, acc} + {1'b0, k_active};
  assign carry   = sum[BITWIDTH];
  // The edge on which the ring steps NPHASE-1 -> 0.
  assign at_wrap = en && carry && (idx == LAST_IDX);

  // Handshake: a word transfers on any edge where kin_valid && kin_ready.
  // kin_ready is high whenever no update is waiting (and never during reset);
  // kin_valid may drop or change freely while kin_ready is low.
  assign kin_ready = !pending && !reset;
  assign transfer  = kin_valid && kin_ready;

  // A stopped ring takes the new word immediately; a running ring only at
  // wrap, so the phase sequence never jumps. The wrap edge itself still
  // accumulates with the old word.
  assign apply = pending && ((k_active == '0) || at_wrap);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      idx       <= RESET_IDX;
      k_active  <= '0;
      k_pend    <= '0;
      mode_q    <= SD_MODE_ONEHOT;
      mode_pend <= SD_MODE_ONEHOT;
      pending   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= at_wrap;
      if (en) begin
        acc <= sum[BITWIDTH-1:0];
        if (carry) begin
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
      end
      // transfer and apply are mutually exclusive (transfer needs !pending).
      if (apply) begin
        k_active <= k_pend;
        mode_q   <= mode_pend;
        pending  <= 1'b0;
      end
      if (transfer) begin
        k_pend    <= kin;
        mode_pend <= mode_in;
        pending   <= 1'b1;
      end
    end
  end

  assign phase_idx = idx;
  assign wrap      = wrap_q;

  sd_phase_decode #(
    .NPHASE(NPHASE)
  ) u_decode (
    .idx   (idx),
    .mode  (mode_q),
    .sd_out(sd_out)
  );

endmodule

// File: tb/tb_sd_multiphase_synth.sv
module tb_sd_multiphase_synth;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] kin;
  logic        mode_in;
  logic        kin_valid;
  logic        kin_ready;
  logic [3:0]  sd_out;
  logic [1:0]  phase_idx;
  logic        wrap;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [31:0] m_acc;
  logic [1:0]  m_idx;
  logic [31:0] m_k;
  logic [31:0] m_kp;
  logic        m_mode;
  logic        m_modep;
  logic        m_pend;
  logic        m_wrap;

  sd_multiphase_synth #(
    .NPHASE(4),
    .BITWIDTH(32),
    .RESETPHASE(0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .kin      (kin),
    .mode_in  (mode_in),
    .kin_valid(kin_valid),
    .kin_ready(kin_ready),
    .sd_out   (sd_out),
    .phase_idx(phase_idx),
    .wrap     (wrap)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected outputs: one-hot is 1<<idx; thermometer is 0011 rotated left by idx.
  function automatic logic [3:0] exp_out(input logic [1:0] i, input logic m);
    logic [7:0] t;
    if (!m) return 4'b0001 << i;
    t = 8'b0011_0011 << i;
    return t[7:4];
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_acc = '0; m_idx = 2'd0; m_k = '0; m_kp = '0;
    m_mode = 1'b0; m_modep = 1'b0; m_pend = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic xfer, input logic [31:0] kv, input logic mv);
    logic [32:0] s;
    logic        w;
    logic        ap;
    s  = {1'b0, m_acc} + {1'b0, m_k};
    w  = e && s[32] && (m_idx == 2'd3);
    ap = m_pend && ((m_k == 32'd0) || w);
    if (e) begin
      m_acc = s[31:0];
      if (s[32]) m_idx = m_idx + 2'd1;
    end
    m_wrap = w;
    if (ap) begin
      m_k = m_kp; m_mode = m_modep; m_pend = 1'b0;
    end
    if (xfer) begin
      m_kp = kv; m_modep = mv; m_pend = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  // One clock edge: sample inputs, advance model, compare after the edge.
  task automatic cyc();
    logic r_s, e_s, m_s, x_s;
    logic [31:0] k_s;
    r_s = reset; e_s = en; k_s = kin; m_s = mode_in;
    x_s = kin_valid && !m_pend && !reset;
    @(posedge clk);
    #1;
    if (r_s) model_reset();
    else model_edge(e_s, x_s, k_s, m_s);
    check("acc", dut.acc, m_acc);
    check("phase_idx", phase_idx, m_idx);
    check("sd_out", sd_out, exp_out(m_idx, m_mode));
    check("wrap", wrap, m_wrap);
    check("kin_ready", kin_ready, !m_pend && !reset);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input logic [31:0] k, input logic m);
    kin = k; mode_in = m; kin_valid = 1'b1;
    cyc();
    kin_valid = 1'b0;
    kin = $urandom_range(32'hFFFF, 0);
    mode_in = 1'($urandom_range(1, 0));
  endtask

  // Run until a wrap pulse is seen; returns cycles taken.
  task automatic wait_wrap(input int budget, output int taken);
    taken = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      taken++;
      if (wrap) return;
    end
    check("wrap_seen", 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    int wraps;
    model_reset();
    reset = 1'b1; en = 1'b0; kin = '0; mode_in = 1'b0; kin_valid = 1'b0;

    // Reset state
    cycles(2);
    check("rst_sd_out", sd_out, 4'b0001);
    check("rst_idx", phase_idx, 2'd0);
    check("rst_wrap", wrap, 1'b0);
    check("rst_ready", kin_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", kin_ready, 1'b1);
    en = 1'b1;
    cycles(3);
    check("stopped_idx", phase_idx, 2'd0);

    // Load 0x40000000 from stopped, one-hot
    load(32'h4000_0000, 1'b0);
    check("xfer_ready_low", kin_ready, 1'b0);
    cyc();
    check("apply_ready", kin_ready, 1'b1);
    check("apply_k", dut.k_active, 32'h4000_0000);
    cycles(4);  check("q_step1", sd_out, 4'b0010);
    cycles(4);  check("q_step2", sd_out, 4'b0100);
    cycles(4);  check("q_step3", sd_out, 4'b1000);
    cycles(4);  check("q_step4", sd_out, 4'b0001);
    check("q_wrap", wrap, 1'b1);
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (wrap) wraps++;
    end
    check("wraps_per_16", wraps, 1);

    // Rate change 0x40000000 -> 0x80000000 requested at idx 1
    cycles(4);
    check("at_idx1", phase_idx, 2'd1);
    load(32'h8000_0000, 1'b0);
    check("pend_ready_low", kin_ready, 1'b0);
    wait_wrap(20, n);
    check("edges_to_wrap", n, 11);
    check("ready_after_wrap", kin_ready, 1'b1);
    check("k_after_wrap", dut.k_active, 32'h8000_0000);
    cycles(2);  check("h_step1", phase_idx, 2'd1);
    cycles(2);  check("h_step2", phase_idx, 2'd2);

    // Stop with kin=0
    load(32'h0, 1'b0);
    wait_wrap(10, n);
    check("stop_sd_out", sd_out, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom_range(1, 0));
      cyc();
      check("stop_hold_idx", phase_idx, 2'd0);
    end
    check("stop_k", dut.k_active, 32'h0);

    // Thermometer mode from stopped, loaded with en=0
    en = 1'b0;
    load(32'h4000_0000, 1'b1);
    cyc();
    check("therm_k", dut.k_active, 32'h4000_0000);
    check("therm0", sd_out, 4'b0011);
    en = 1'b1;
    cycles(4);  check("therm1", sd_out, 4'b0110);
    cycles(4);  check("therm2", sd_out, 4'b1100);
    cycles(4);  check("therm3", sd_out, 4'b1001);
    cycles(4);  check("therm4", sd_out, 4'b0011);

    // Stop, then run at full-scale word
    load(32'h0, 1'b0);
    wait_wrap(20, n);
    check("stop2_sd_out", sd_out, 4'b0001);
    load(32'hFFFF_FFFF, 1'b0);
    cyc();
    check("fs_k", dut.k_active, 32'hFFFF_FFFF);
    cyc();  check("fs_first", phase_idx, 2'd0);
    cyc();  check("fs_second", phase_idx, 2'd1);
    cyc();  check("fs_third", phase_idx, 2'd2);
    cyc();  check("fs_fourth", phase_idx, 2'd3);

    // Reset while an update is pending
    load(32'h1234_5678, 1'b1);
    check("mid_pending", dut.pending, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("rp_k", dut.k_active, 32'h0);
    check("rp_pending", dut.pending, 1'b0);
    check("rp_idx", phase_idx, 2'd0);
    check("rp_ready", kin_ready, 1'b1);
    cycles(5);
    check("rp_no_adv", phase_idx, 2'd0);
    check("rp_acc", dut.acc, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
